// File: rtl/audio_frame_sequencer_if.sv
// rtl/audio_frame_sequencer_if.sv - control and tick/step bundle for the audio frame sequencer
interface audio_frame_sequencer_if #(
  parameter int STEP_W   = 3,
  parameter int NUM_TAPS = 3
);
  logic                enable;
  logic                restart;
  logic                ext_tick;
  logic [STEP_W-1:0]   step;
  logic                base_tick;
  logic [NUM_TAPS-1:0] tap_tick;
  logic [NUM_TAPS-1:0] tap_level;
  logic                wrap;

  modport master (
    output enable, restart, ext_tick,
    input  step, base_tick, tap_tick, tap_level, wrap
  );

  modport slave (
    input  enable, restart, ext_tick,
    output step, base_tick, tap_tick, tap_level, wrap
  );
endinterface

// File: rtl/audio_frame_sequencer.sv
// rtl/audio_frame_sequencer.sv - prescaled step counter with binary-divided tap pulses and levels
module audio_frame_sequencer #(
  parameter int PRESCALE = 32768,
  parameter int STEP_W   = 3,
  parameter int NUM_TAPS = 3,
  parameter int EXT_TICK = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  audio_frame_sequencer_if.slave  bus
);
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0]    pre_cnt;
  logic [STEP_W-1:0]   step_q;
  logic                base_tick_q;
  logic [NUM_TAPS-1:0] tap_tick_q;
  logic                wrap_q;

  logic                tick;
  logic [STEP_W-1:0]   step_next;
  logic [NUM_TAPS-1:0] tap_next;
  logic                low_zero;

  always_comb begin
    tick = 1'b0;
    if (EXT_TICK != 0) begin
      tick = bus.enable & bus.ext_tick;
    end else begin
      tick = bus.enable & (pre_cnt == PRE_LAST);
    end
    step_next = step_q + STEP_W'(1);
    // tap k fires when the low k+1 bits of the new step are all zero
    low_zero = 1'b1;
    tap_next = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      low_zero    = low_zero & ~step_next[k];
      tap_next[k] = low_zero;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre_cnt     <= '0;
      step_q      <= '0;
      base_tick_q <= 1'b0;
      tap_tick_q  <= '0;
      wrap_q      <= 1'b0;
    end else if (bus.restart) begin
      pre_cnt     <= '0;
      step_q      <= '0;
      base_tick_q <= 1'b0;
      tap_tick_q  <= '0;
      wrap_q      <= 1'b0;
    end else begin
      base_tick_q <= 1'b0;
      tap_tick_q  <= '0;
      wrap_q      <= 1'b0;
      if (EXT_TICK == 0 && bus.enable) begin
        pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
      end
      if (tick) begin
        step_q      <= step_next;
        base_tick_q <= 1'b1;
        tap_tick_q  <= tap_next;
        wrap_q      <= (step_next == '0);
      end
    end
  end

  assign bus.step      = step_q;
  assign bus.base_tick = base_tick_q;
  assign bus.tap_tick  = tap_tick_q;
  assign bus.tap_level = step_q[NUM_TAPS-1:0];
  assign bus.wrap      = wrap_q;
endmodule

// File: tb/tb_audio_frame_sequencer.sv
// tb/tb_audio_frame_sequencer.sv - directed self-checking bench for audio_frame_sequencer
module tb_audio_frame_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  audio_frame_sequencer_if #(.STEP_W(3), .NUM_TAPS(3)) bus_a ();
  audio_frame_sequencer_if #(.STEP_W(3), .NUM_TAPS(3)) bus_b ();
  audio_frame_sequencer_if #(.STEP_W(3), .NUM_TAPS(3)) bus_c ();

  audio_frame_sequencer #(.PRESCALE(4), .STEP_W(3), .NUM_TAPS(3), .EXT_TICK(0))
    dut_a (.clock(clock), .reset(reset), .bus(bus_a));
  audio_frame_sequencer #(.PRESCALE(4), .STEP_W(3), .NUM_TAPS(3), .EXT_TICK(1))
    dut_b (.clock(clock), .reset(reset), .bus(bus_b));
  audio_frame_sequencer #(.PRESCALE(1), .STEP_W(3), .NUM_TAPS(3), .EXT_TICK(0))
    dut_c (.clock(clock), .reset(reset), .bus(bus_c));

  // {step[2:0], base_tick, tap_tick[2:0], tap_level[2:0], wrap}
  wire [10:0] obs_a = {bus_a.step, bus_a.base_tick, bus_a.tap_tick, bus_a.tap_level, bus_a.wrap};
  wire [10:0] obs_b = {bus_b.step, bus_b.base_tick, bus_b.tap_tick, bus_b.tap_level, bus_b.wrap};
  wire [10:0] obs_c = {bus_c.step, bus_c.base_tick, bus_c.tap_tick, bus_c.tap_level, bus_c.wrap};

  function automatic logic [10:0] exp_vec(input logic bt, input int s);
    logic [2:0] sv;
    logic [2:0] tt;
    sv = 3'(s);
    tt[0] = bt && (s % 2 == 0);
    tt[1] = bt && (s % 4 == 0);
    tt[2] = bt && (s == 0);
    return {sv, bt, tt, sv, bt && (s == 0)};
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus_a.enable = 0; bus_a.restart = 0; bus_a.ext_tick = 0;
    bus_b.enable = 0; bus_b.restart = 0; bus_b.ext_tick = 0;
    bus_c.enable = 0; bus_c.restart = 0; bus_c.ext_tick = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    idle_inputs();
    cyc();
    cyc();
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (obs_a !== 11'd0) begin fails++; $display("FAIL reset_a got=%b exp=%b", obs_a, 11'd0); end
    tests++;
    if (obs_b !== 11'd0) begin fails++; $display("FAIL reset_b got=%b exp=%b", obs_b, 11'd0); end
    tests++;
    if (obs_c !== 11'd0) begin fails++; $display("FAIL reset_c got=%b exp=%b", obs_c, 11'd0); end
  endtask

  task automatic test_count();
    logic [10:0] e;
    do_reset();
    bus_a.enable = 1;
    reset = 0;
    for (int c = 1; c <= 40; c++) begin
      cyc();
      e = exp_vec(c % 4 == 0, (c / 4) % 8);
      tests++;
      if (obs_a !== e) begin fails++; $display("FAIL count c=%0d got=%b exp=%b", c, obs_a, e); end
    end
  endtask

  task automatic test_enable();
    logic [10:0] e;
    do_reset();
    bus_a.enable = 1;
    reset = 0;
    for (int c = 1; c <= 22; c++) cyc();
    bus_a.enable = 0;
    for (int c = 0; c < 10; c++) begin
      cyc();
      e = exp_vec(0, 5);
      tests++;
      if (obs_a !== e) begin fails++; $display("FAIL enable_hold c=%0d got=%b exp=%b", c, obs_a, e); end
    end
    bus_a.enable = 1;
    cyc();
    e = exp_vec(0, 5);
    tests++;
    if (obs_a !== e) begin fails++; $display("FAIL enable_resume1 got=%b exp=%b", obs_a, e); end
    cyc();
    e = exp_vec(1, 6);
    tests++;
    if (obs_a !== e) begin fails++; $display("FAIL enable_resume2 got=%b exp=%b", obs_a, e); end
  endtask

  task automatic test_restart();
    logic [10:0] e;
    do_reset();
    bus_a.enable = 1;
    reset = 0;
    for (int c = 1; c <= 31; c++) cyc();
    e = exp_vec(0, 7);
    tests++;
    if (obs_a !== e) begin fails++; $display("FAIL restart_pre got=%b exp=%b", obs_a, e); end
    bus_a.restart = 1;
    cyc();
    tests++;
    if (obs_a !== 11'd0) begin fails++; $display("FAIL restart_clear got=%b exp=%b", obs_a, 11'd0); end
    cyc();
    tests++;
    if (obs_a !== 11'd0) begin fails++; $display("FAIL restart_held got=%b exp=%b", obs_a, 11'd0); end
    bus_a.restart = 0;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      e = (c == 4) ? exp_vec(1, 1) : exp_vec(0, 0);
      tests++;
      if (obs_a !== e) begin fails++; $display("FAIL restart_resume c=%0d got=%b exp=%b", c, obs_a, e); end
    end
  endtask

  task automatic test_async_reset();
    logic [10:0] e;
    do_reset();
    bus_a.enable = 1;
    reset = 0;
    for (int c = 1; c <= 4; c++) cyc();
    e = exp_vec(1, 1);
    tests++;
    if (obs_a !== e) begin fails++; $display("FAIL async_pre got=%b exp=%b", obs_a, e); end
    #2 reset = 1;
    #1;
    tests++;
    if (obs_a !== 11'd0) begin fails++; $display("FAIL async_clear got=%b exp=%b", obs_a, 11'd0); end
    cyc();
    reset = 0;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      e = (c == 4) ? exp_vec(1, 1) : exp_vec(0, 0);
      tests++;
      if (obs_a !== e) begin fails++; $display("FAIL async_resume c=%0d got=%b exp=%b", c, obs_a, e); end
    end
  endtask

  task automatic test_ext_tick();
    logic [10:0] e;
    do_reset();
    reset = 0;
    cyc();
    tests++;
    if (obs_b !== 11'd0) begin fails++; $display("FAIL ext_idle got=%b exp=%b", obs_b, 11'd0); end
    bus_b.enable = 1;
    bus_b.ext_tick = 1;
    for (int c = 1; c <= 3; c++) begin
      cyc();
      e = exp_vec(1, c);
      tests++;
      if (obs_b !== e) begin fails++; $display("FAIL ext_step c=%0d got=%b exp=%b", c, obs_b, e); end
    end
    bus_b.enable = 0;
    for (int c = 1; c <= 3; c++) begin
      cyc();
      e = exp_vec(0, 3);
      tests++;
      if (obs_b !== e) begin fails++; $display("FAIL ext_disabled c=%0d got=%b exp=%b", c, obs_b, e); end
    end
  endtask

  task automatic test_prescale1();
    logic [10:0] e;
    int wraps;
    wraps = 0;
    do_reset();
    bus_c.enable = 1;
    reset = 0;
    for (int c = 1; c <= 9; c++) begin
      cyc();
      if (bus_c.wrap === 1'b1) wraps++;
      e = exp_vec(1, c % 8);
      tests++;
      if (obs_c !== e) begin fails++; $display("FAIL pre1 c=%0d got=%b exp=%b", c, obs_c, e); end
    end
    tests++;
    if (wraps !== 1) begin fails++; $display("FAIL pre1_wraps got=%0d exp=%0d", wraps, 1); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_count();
    test_enable();
    test_restart();
    test_async_reset();
    test_ext_tick();
    test_prescale1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
